bufer_ex_mem_skid: RTL and testbench
====================================

# bufer_ex_mem_skid

Clocked, parametrised EX/MEM pipeline stage register with valid/ready flow control, flush, and a one-entry skid buffer. It carries the branch-target sum, zero flag, ALU result, second register read value and MEM-stage control bits from the execute stage to the memory stage. It succeeds the combinational EX/MEM pass-through: it adds true pipeline registration, backpressure from MEM, and squash on taken branches or exceptions.

## Interface
Parameters:
- DATA_W, 32, width of add_res, alu_res and dato_lec2 fields
- CTRL_W, 1, width of MEM-stage control bundle (bit 0 = MuxD select)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_add_res  in  DATA_W  branch target from EX adder
- in_zero_flag  in  1  ALU zero flag
- in_alu_res  in  DATA_W  ALU result
- in_dato_lec2  in  DATA_W  register read port 2 (store data)
- in_ctrl  in  CTRL_W  MEM/WB control bits
- in_valid  in  1  EX presents a beat
- in_ready  out  1  stage can accept; registered
- flush  in  1  squash all held beats
- out_add_res, out_zero_flag, out_alu_res, out_dato_lec2, out_ctrl  out  same widths  registered payload to MEM
- out_valid  out  1  payload valid
- out_ready  in  1  MEM accepts
- occupancy  out  2  beats held, 0..2

## Operation
- A beat transfers on input when in_valid & in_ready; on output when out_valid & out_ready.
- Storage: main register, which drives the out_* ports, plus a skid register.
- States: EMPTY (occupancy 0), ONE (main valid), FULL (main + skid valid).
- EMPTY: in_valid -> ONE, main <= input.
- ONE:
  - in_valid & out_ready -> ONE, main <= input.
  - in_valid & !out_ready -> FULL, skid <= input.
  - !in_valid & out_ready -> EMPTY.
  - otherwise hold.
- FULL: in_ready = 0, so no input accepted.
  - out_ready -> ONE, main <= skid.
  - otherwise hold.
- flush has highest priority:
  - next state EMPTY in any state; the input beat of that cycle is discarded.
  - An output handshake in the flush cycle (out_valid & out_ready) still counts as delivered.
  - Payload registers are not cleared by flush; only the valid state is.
- While out_valid & !out_ready, all out_* are held bit-stable.
- Order is strictly preserved: the main beat always leaves before the skid beat.
- No arithmetic on payload; fields pass unchanged.

## Timing
- Latency: input handshake at edge N -> out_valid with that payload after edge N, visible in cycle N+1, when the stage was EMPTY or in ONE with out_ready high.
- in_ready = (next state != FULL), registered; it never depends combinationally on out_ready.
- Throughput: one beat per cycle with out_ready held high.
- Reset (asynchronous assert, released synchronously by the system) sets:
  - state EMPTY, out_valid 0, in_ready 1, occupancy 0
  - all out_* payload 0, skid 0
- Reset mid-transfer drops all held beats; no beat appears at the output after reset deassertion until a new input handshake.
- Simultaneous flush & in_valid & in_ready: the input is not captured, and in_ready is 1 the next cycle.
- occupancy is registered and equals the state encoding (0/1/2).

## Structure
- Package bufer_pkg holds:
  - state enum {EMPTY, ONE, FULL}
  - localparam PAYLOAD_W = 3*DATA_W + 1 + CTRL_W
  - packed payload layout (add_res, zero, alu_res, dato_lec2, ctrl, MSB to LSB)
- Sub-module stage_reg: PAYLOAD_W-wide register with load enable and asynchronous reset to 0. Instantiated twice, once for main and once for skid.
- The FSM and handshake logic live in the top module.

## Test plan
- Reset with all inputs X -> out_valid=0, in_ready=1, occupancy=0, out_alu_res=0.
- Stream 4 beats with alu_res 0x10..0x13, out_ready=1 -> each appears one cycle after accept, in order, in_ready stays 1.
- Accept alu_res 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_alu_res held 0xA. Raise out_ready -> 0xA, then 0xB, delivered; in_ready returns to 1.
- FULL state, assert flush with in_valid=1 and alu_res=0xC -> next cycle out_valid=0, occupancy=0; 0xC never appears.
- ONE state holding 0xD, flush and out_ready both 1 -> 0xD is counted as delivered and the stage goes EMPTY.
- Assert rst asynchronously mid-cycle in FULL -> out_valid drops immediately, without a clock edge; after release the first output equals the first new input.

Source files
------------

// File: rtl/bufer_pkg.sv
// Shared types and sizing for the EX/MEM skid stage.
package bufer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 1;
  localparam int PAYLOAD_W  = 3*DATA_W_DEF + 1 + CTRL_W_DEF;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] add_res;
    logic                  zero;
    logic [DATA_W_DEF-1:0] alu_res;
    logic [DATA_W_DEF-1:0] dato_lec2;
    logic [CTRL_W_DEF-1:0] ctrl;
  } payload_t;

  function automatic int payload_w(input int dw, input int cw);
    return 3*dw + 1 + cw;
  endfunction

endpackage

// File: rtl/bufer_ex_mem_skid_stage_reg.sv
// Payload register with load enable, async clear.
module stage_reg #(
  parameter int W = 97
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     data_q <= '0;
    else if (en_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/bufer_ex_mem_skid.sv
// EX/MEM pipeline register with valid/ready, flush and
// a one-entry skid buffer behind the main register.
module bufer_ex_mem_skid
  import bufer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_add_res,
  input  logic              in_zero_flag,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_dato_lec2,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] out_add_res,
  output logic              out_zero_flag,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_dato_lec2,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  localparam int PW = payload_w(DATA_W, CTRL_W);

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   ld_main, ld_skid, sel_skid;
  logic   in_fire;

  logic [PW-1:0] in_pl, main_d, main_q, skid_q;

  assign in_pl = {in_add_res, in_zero_flag, in_alu_res,
                  in_dato_lec2, in_ctrl};

  assign in_fire   = in_valid & in_ready_q;
  assign out_valid = (state_q != EMPTY);

  always_comb begin
    state_d  = state_q;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    sel_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          ld_main = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_ready) begin
          ld_main = 1'b1;
        end else if (in_fire) begin
          state_d = FULL;
          ld_skid = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d  = ONE;
          ld_main  = 1'b1;
          sel_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash wins over everything; payload regs keep stale bits.
    if (flush) begin
      state_d = EMPTY;
      ld_main = 1'b0;
      ld_skid = 1'b0;
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign main_d = sel_skid ? skid_q : in_pl;

  stage_reg #(.W(PW)) u_main (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (ld_main),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  stage_reg #(.W(PW)) u_skid (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (ld_skid),
    .d_i   (in_pl),
    .q_o   (skid_q)
  );

  assign {out_add_res, out_zero_flag, out_alu_res,
          out_dato_lec2, out_ctrl} = main_q;

  assign in_ready  = in_ready_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_bufer_ex_mem_skid.sv
// Self-checking bench: queue model plus directed literals.
module tb_bufer_ex_mem_skid;

  localparam int DW = 32;
  localparam int CW = 1;
  localparam int PW = 3*DW + 1 + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_add_res, in_alu_res, in_dato_lec2;
  logic          in_zero_flag;
  logic [CW-1:0] in_ctrl;
  logic          in_valid, in_ready, flush;
  logic [DW-1:0] out_add_res, out_alu_res, out_dato_lec2;
  logic          out_zero_flag;
  logic [CW-1:0] out_ctrl;
  logic          out_valid, out_ready;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] mq[$];
  logic [DW-1:0] deliv[$];

  bufer_ex_mem_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_add_res    (in_add_res),
    .in_zero_flag  (in_zero_flag),
    .in_alu_res    (in_alu_res),
    .in_dato_lec2  (in_dato_lec2),
    .in_ctrl       (in_ctrl),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .flush         (flush),
    .out_add_res   (out_add_res),
    .out_zero_flag (out_zero_flag),
    .out_alu_res   (out_alu_res),
    .out_dato_lec2 (out_dato_lec2),
    .out_ctrl      (out_ctrl),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: FIFO of held beats, at most two.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      automatic bit ir = (mq.size() < 2);
      automatic bit ov = (mq.size() > 0);
      if (ov && out_ready === 1'b1) void'(mq.pop_front());
      if (flush === 1'b1) mq.delete();
      else if (in_valid === 1'b1 && ir)
        mq.push_back({in_add_res, in_zero_flag, in_alu_res,
                      in_dato_lec2, in_ctrl});
    end
  end

  always @(posedge clk)
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1)
      deliv.push_back(out_alu_res);

  always @(negedge clk) begin
    chk("out_valid", out_valid, mq.size() > 0);
    chk("occupancy", occupancy, mq.size());
    chk("in_ready", in_ready, mq.size() < 2);
    if (mq.size() > 0)
      chk("payload", {out_add_res, out_zero_flag, out_alu_res,
                      out_dato_lec2, out_ctrl}, mq[0]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [DW-1:0] a);
    in_valid     = v;
    in_alu_res   = a;
    in_add_res   = a + 32'h1000;
    in_zero_flag = a[0];
    in_dato_lec2 = ~a;
    in_ctrl      = a[1];
  endtask

  initial begin
    int n;
    rst = 1'b1;
    flush = 1'bx;
    out_ready = 1'bx;
    in_valid = 1'bx;
    in_alu_res = 'x;
    in_add_res = 'x;
    in_dato_lec2 = 'x;
    in_zero_flag = 1'bx;
    in_ctrl = 'x;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_alu", out_alu_res, 32'h0);
    flush = 1'b0;
    out_ready = 1'b1;
    beat(1'b0, 32'h0);
    cyc();
    rst = 1'b0;

    // Streaming with MEM always ready.
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 32'h10 + i);
      cyc();
      chk("stream_alu", out_alu_res, 32'h10 + i);
      chk("stream_rdy", in_ready, 1'b1);
    end
    beat(1'b0, 32'h0);
    cyc();
    chk("stream_n", deliv.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("stream_ord", deliv[i], 32'h10 + i);

    // Backpressure fills the skid.
    out_ready = 1'b0;
    beat(1'b1, 32'hA);
    cyc();
    beat(1'b1, 32'hB);
    cyc();
    beat(1'b0, 32'h0);
    chk("bp_occ", occupancy, 2'd2);
    chk("bp_rdy", in_ready, 1'b0);
    chk("bp_alu", out_alu_res, 32'hA);
    cyc();
    chk("bp_hold", out_alu_res, 32'hA);
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("bp_d0", deliv[deliv.size()-2], 32'hA);
    chk("bp_d1", deliv[deliv.size()-1], 32'hB);
    chk("bp_rdy2", in_ready, 1'b1);

    // Flush in FULL discards the incoming beat.
    out_ready = 1'b0;
    beat(1'b1, 32'h20);
    cyc();
    beat(1'b1, 32'h21);
    cyc();
    n = deliv.size();
    flush = 1'b1;
    beat(1'b1, 32'hC);
    cyc();
    flush = 1'b0;
    beat(1'b0, 32'h0);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_occ", occupancy, 2'd0);
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("fl_none", deliv.size(), n);

    // Flush with a handshake in ONE still delivers.
    out_ready = 1'b0;
    beat(1'b1, 32'hD);
    cyc();
    beat(1'b0, 32'h0);
    flush = 1'b1;
    out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fo_last", deliv[deliv.size()-1], 32'hD);
    chk("fo_occ", occupancy, 2'd0);
    chk("fo_rdy", in_ready, 1'b1);

    // Async reset in FULL.
    out_ready = 1'b0;
    beat(1'b1, 32'h30);
    cyc();
    beat(1'b1, 32'h31);
    cyc();
    beat(1'b0, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_occ", occupancy, 2'd0);
    n = deliv.size();
    out_ready = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("ar_quiet", out_valid, 1'b0);
    beat(1'b1, 32'h40);
    cyc();
    beat(1'b0, 32'h0);
    cyc();
    chk("ar_n", deliv.size(), n + 1);
    chk("ar_first", deliv[deliv.size()-1], 32'h40);

    cyc();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
